// File: rtl/ldpc_addr_gen.sv
// rtl/ldpc_addr_gen.sv - edge/LLR RAM address generator for the LDPC decoder
// Two column-major VPU channels and one row-major CPU channel, each with a registered done pulse.
module ldpc_addr_gen #(
  parameter int N_ROW      = 4,
  parameter int N_COL      = 24,
  parameter int ADDR_WIDTH = 8,
  parameter int COL_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ini_st,
  input  logic                  vpu_rd_addr_en,
  input  logic                  vpu_wr_addr_en,
  input  logic                  cpu_wr_addr_en,
  output logic [ADDR_WIDTH-1:0] vpu_rd_addr,
  output logic [ADDR_WIDTH-1:0] vpu_wr_addr,
  output logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [COL_WIDTH-1:0]  llr_addr,
  output logic                  vpu_rd_done,
  output logic                  vpu_wr_done,
  output logic                  cpu_wr_done
);

  localparam int ROW_WIDTH = (N_ROW > 1) ? $clog2(N_ROW) : 1;

  localparam logic [ROW_WIDTH-1:0]  ROW_LAST  = ROW_WIDTH'(N_ROW - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_ONE   = ROW_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0]  COL_LAST  = COL_WIDTH'(N_COL - 1);
  localparam logic [COL_WIDTH-1:0]  COL_ONE   = COL_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N_ROW * N_COL - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(N_COL);

  logic [ROW_WIDTH-1:0]  rd_r_q, rd_r_d, wr_r_q, wr_r_d;
  logic [COL_WIDTH-1:0]  rd_c_q, rd_c_d, wr_c_q, wr_c_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
  logic                  rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic                  cpu_done_q, cpu_done_d;

  // Column-major walk is incremental: step down a column by +N_COL, then jump to the next column head.
  always_comb begin
    rd_r_d    = rd_r_q;
    rd_c_d    = rd_c_q;
    rd_addr_d = rd_addr_q;
    rd_done_d = 1'b0;
    if (ini_st) begin
      rd_r_d    = '0;
      rd_c_d    = '0;
      rd_addr_d = '0;
    end else if (vpu_rd_addr_en) begin
      if (rd_r_q != ROW_LAST) begin
        rd_r_d    = rd_r_q + ROW_ONE;
        rd_addr_d = rd_addr_q + ADDR_STEP;
      end else if (rd_c_q == COL_LAST) begin
        rd_r_d    = '0;
        rd_c_d    = '0;
        rd_addr_d = '0;
        rd_done_d = 1'b1;
      end else begin
        rd_r_d    = '0;
        rd_c_d    = rd_c_q + COL_ONE;
        rd_addr_d = ADDR_WIDTH'(rd_c_q) + ADDR_ONE;
      end
    end
  end

  always_comb begin
    wr_r_d    = wr_r_q;
    wr_c_d    = wr_c_q;
    wr_addr_d = wr_addr_q;
    wr_done_d = 1'b0;
    if (ini_st) begin
      wr_r_d    = '0;
      wr_c_d    = '0;
      wr_addr_d = '0;
    end else if (vpu_wr_addr_en) begin
      if (wr_r_q != ROW_LAST) begin
        wr_r_d    = wr_r_q + ROW_ONE;
        wr_addr_d = wr_addr_q + ADDR_STEP;
      end else if (wr_c_q == COL_LAST) begin
        wr_r_d    = '0;
        wr_c_d    = '0;
        wr_addr_d = '0;
        wr_done_d = 1'b1;
      end else begin
        wr_r_d    = '0;
        wr_c_d    = wr_c_q + COL_ONE;
        wr_addr_d = ADDR_WIDTH'(wr_c_q) + ADDR_ONE;
      end
    end
  end

  always_comb begin
    cpu_addr_d = cpu_addr_q;
    cpu_done_d = 1'b0;
    if (ini_st) begin
      cpu_addr_d = '0;
    end else if (cpu_wr_addr_en) begin
      if (cpu_addr_q == ADDR_LAST) begin
        cpu_addr_d = '0;
        cpu_done_d = 1'b1;
      end else begin
        cpu_addr_d = cpu_addr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r_q     <= '0;
      rd_c_q     <= '0;
      rd_addr_q  <= '0;
      rd_done_q  <= 1'b0;
      wr_r_q     <= '0;
      wr_c_q     <= '0;
      wr_addr_q  <= '0;
      wr_done_q  <= 1'b0;
      cpu_addr_q <= '0;
      cpu_done_q <= 1'b0;
    end else begin
      rd_r_q     <= rd_r_d;
      rd_c_q     <= rd_c_d;
      rd_addr_q  <= rd_addr_d;
      rd_done_q  <= rd_done_d;
      wr_r_q     <= wr_r_d;
      wr_c_q     <= wr_c_d;
      wr_addr_q  <= wr_addr_d;
      wr_done_q  <= wr_done_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_done_q <= cpu_done_d;
    end
  end

  assign vpu_rd_addr = rd_addr_q;
  assign vpu_wr_addr = wr_addr_q;
  assign cpu_wr_addr = cpu_addr_q;
  assign llr_addr    = rd_c_q;
  assign vpu_rd_done = rd_done_q;
  assign vpu_wr_done = wr_done_q;
  assign cpu_wr_done = cpu_done_q;

endmodule

// File: tb/tb_ldpc_addr_gen.sv
// tb/tb_ldpc_addr_gen.sv - scoreboard bench for ldpc_addr_gen
// Expected state is computed from (r, c) as r*N_COL + c and queued per driven cycle.
module tb_ldpc_addr_gen;

  localparam int N_ROW = 4;
  localparam int N_COL = 24;
  localparam int AW    = 8;
  localparam int CW    = 5;
  localparam int E     = N_ROW * N_COL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ini_st = 1'b0;
  logic          vpu_rd_addr_en = 1'b0;
  logic          vpu_wr_addr_en = 1'b0;
  logic          cpu_wr_addr_en = 1'b0;
  logic [AW-1:0] vpu_rd_addr, vpu_wr_addr, cpu_wr_addr;
  logic [CW-1:0] llr_addr;
  logic          vpu_rd_done, vpu_wr_done, cpu_wr_done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int rd_addr;
    int llr;
    int wr_addr;
    int cpu_addr;
    bit rd_done;
    bit wr_done;
    bit cpu_done;
  } exp_t;

  exp_t sb[$];

  int m_rd_r, m_rd_c, m_wr_r, m_wr_c, m_cpu;
  bit m_rd_done, m_wr_done, m_cpu_done;

  ldpc_addr_gen #(.N_ROW(N_ROW), .N_COL(N_COL), .ADDR_WIDTH(AW), .COL_WIDTH(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ini_st(ini_st),
    .vpu_rd_addr_en(vpu_rd_addr_en),
    .vpu_wr_addr_en(vpu_wr_addr_en),
    .cpu_wr_addr_en(cpu_wr_addr_en),
    .vpu_rd_addr(vpu_rd_addr),
    .vpu_wr_addr(vpu_wr_addr),
    .cpu_wr_addr(cpu_wr_addr),
    .llr_addr(llr_addr),
    .vpu_rd_done(vpu_rd_done),
    .vpu_wr_done(vpu_wr_done),
    .cpu_wr_done(cpu_wr_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_rd_r = 0; m_rd_c = 0; m_wr_r = 0; m_wr_c = 0; m_cpu = 0;
    m_rd_done = 0; m_wr_done = 0; m_cpu_done = 0;
  endtask

  // Drives one cycle from a negedge, advances the model, queues the post-edge expectation.
  task automatic cycle(input bit rd, input bit wr, input bit cpu, input bit ini);
    exp_t e;
    vpu_rd_addr_en = rd;
    vpu_wr_addr_en = wr;
    cpu_wr_addr_en = cpu;
    ini_st         = ini;
    if (ini) begin
      model_reset();
    end else begin
      m_rd_done = 0;
      if (rd) begin
        if (m_rd_r < N_ROW - 1) m_rd_r++;
        else begin
          m_rd_r = 0;
          if (m_rd_c == N_COL - 1) begin m_rd_c = 0; m_rd_done = 1; end
          else m_rd_c++;
        end
      end
      m_wr_done = 0;
      if (wr) begin
        if (m_wr_r < N_ROW - 1) m_wr_r++;
        else begin
          m_wr_r = 0;
          if (m_wr_c == N_COL - 1) begin m_wr_c = 0; m_wr_done = 1; end
          else m_wr_c++;
        end
      end
      m_cpu_done = 0;
      if (cpu) begin
        m_cpu_done = (m_cpu == E - 1);
        m_cpu = (m_cpu + 1) % E;
      end
    end
    e.rd_addr  = m_rd_r * N_COL + m_rd_c;
    e.llr      = m_rd_c;
    e.wr_addr  = m_wr_r * N_COL + m_wr_c;
    e.cpu_addr = m_cpu;
    e.rd_done  = m_rd_done;
    e.wr_done  = m_wr_done;
    e.cpu_done = m_cpu_done;
    sb.push_back(e);
    @(negedge clk);
    vpu_rd_addr_en = 1'b0;
    vpu_wr_addr_en = 1'b0;
    cpu_wr_addr_en = 1'b0;
    ini_st         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({vpu_rd_addr, vpu_wr_addr, cpu_wr_addr, llr_addr, vpu_rd_done, vpu_wr_done, cpu_wr_done} !== '0)
      $display("FAIL reset outputs got rd=%0d wr=%0d cpu=%0d llr=%0d done=%b%b%b want all 0",
               vpu_rd_addr, vpu_wr_addr, cpu_wr_addr, llr_addr, vpu_rd_done, vpu_wr_done, cpu_wr_done);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({vpu_rd_addr, cpu_wr_addr, vpu_rd_done} !== '0)
      $display("FAIL reset_idle got rd=%0d cpu=%0d done=%b want 0/0/0", vpu_rd_addr, cpu_wr_addr, vpu_rd_done);
    else n_pass++;
  endtask

  task automatic test_vpu_rd_sweep();
    exp_t e;
    for (int i = 0; i < E + 1; i++) begin
      cycle(i < E, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (vpu_rd_addr !== AW'(e.rd_addr) || llr_addr !== CW'(e.llr) || vpu_rd_done !== e.rd_done)
        $display("FAIL rd_sweep[%0d] got addr=%0d llr=%0d done=%b want addr=%0d llr=%0d done=%b",
                 i, vpu_rd_addr, llr_addr, vpu_rd_done, e.rd_addr, e.llr, e.rd_done);
      else n_pass++;
    end
  endtask

  task automatic test_cpu_sweep();
    exp_t e;
    for (int i = 0; i < E + 1; i++) begin
      cycle(1'b0, 1'b0, i < E, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (cpu_wr_addr !== AW'(e.cpu_addr) || cpu_wr_done !== e.cpu_done || vpu_rd_addr !== AW'(e.rd_addr))
        $display("FAIL cpu_sweep[%0d] got addr=%0d done=%b rd=%0d want addr=%0d done=%b rd=%0d",
                 i, cpu_wr_addr, cpu_wr_done, vpu_rd_addr, e.cpu_addr, e.cpu_done, e.rd_addr);
      else n_pass++;
    end
  endtask

  task automatic test_toggle();
    exp_t e;
    bit pattern [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cycle(pattern[i], 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (vpu_rd_addr !== AW'(e.rd_addr) || vpu_rd_done !== 1'b0)
        $display("FAIL toggle[%0d] got addr=%0d done=%b want addr=%0d done=0",
                 i, vpu_rd_addr, vpu_rd_done, e.rd_addr);
      else n_pass++;
    end
  endtask

  task automatic test_ini_abort();
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (vpu_wr_addr !== AW'(e.wr_addr) || vpu_wr_done !== e.wr_done)
        $display("FAIL wr_partial[%0d] got addr=%0d done=%b want addr=%0d done=%b",
                 i, vpu_wr_addr, vpu_wr_done, e.wr_addr, e.wr_done);
      else n_pass++;
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if ({vpu_wr_addr, vpu_wr_done, vpu_rd_addr, llr_addr, cpu_wr_addr} !== '0 || e.wr_addr != 0)
      $display("FAIL ini_abort got wr=%0d done=%b rd=%0d llr=%0d cpu=%0d want all 0",
               vpu_wr_addr, vpu_wr_done, vpu_rd_addr, llr_addr, cpu_wr_addr);
    else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (vpu_wr_addr !== AW'(e.wr_addr) || vpu_wr_done !== 1'b0)
      $display("FAIL ini_restart got wr=%0d done=%b want wr=%0d done=0", vpu_wr_addr, vpu_wr_done, e.wr_addr);
    else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_all_three();
    exp_t e;
    for (int i = 0; i < E; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (vpu_rd_addr !== AW'(e.rd_addr) || vpu_wr_addr !== AW'(e.wr_addr) ||
          cpu_wr_addr !== AW'(e.cpu_addr) || llr_addr !== CW'(e.llr) ||
          {vpu_rd_done, vpu_wr_done, cpu_wr_done} !== {e.rd_done, e.wr_done, e.cpu_done})
        $display("FAIL all_three[%0d] got rd=%0d wr=%0d cpu=%0d llr=%0d done=%b%b%b want rd=%0d wr=%0d cpu=%0d llr=%0d done=%b%b%b",
                 i, vpu_rd_addr, vpu_wr_addr, cpu_wr_addr, llr_addr, vpu_rd_done, vpu_wr_done, cpu_wr_done,
                 e.rd_addr, e.wr_addr, e.cpu_addr, e.llr, e.rd_done, e.wr_done, e.cpu_done);
      else n_pass++;
    end
    n_checks++;
    if ({vpu_rd_done, vpu_wr_done, cpu_wr_done} !== 3'b111)
      $display("FAIL all_three_done got %b%b%b want 111", vpu_rd_done, vpu_wr_done, cpu_wr_done);
    else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if ({vpu_rd_done, vpu_wr_done, cpu_wr_done} !== 3'b000)
      $display("FAIL done_width got %b%b%b want 000", vpu_rd_done, vpu_wr_done, cpu_wr_done);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 49; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
    end
    n_checks++;
    if (vpu_rd_addr !== AW'(e.rd_addr) || llr_addr !== CW'(e.llr))
      $display("FAIL pre_async got addr=%0d llr=%0d want addr=%0d llr=%0d", vpu_rd_addr, llr_addr, e.rd_addr, e.llr);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vpu_rd_addr, llr_addr, vpu_rd_done, vpu_wr_done, cpu_wr_done} !== '0)
      $display("FAIL async_reset got addr=%0d llr=%0d done=%b%b%b want all 0",
               vpu_rd_addr, llr_addr, vpu_rd_done, vpu_wr_done, cpu_wr_done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (vpu_rd_addr !== AW'(e.rd_addr) || llr_addr !== CW'(e.llr))
      $display("FAIL post_async got addr=%0d llr=%0d want addr=%0d llr=%0d", vpu_rd_addr, llr_addr, e.rd_addr, e.llr);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vpu_rd_sweep();
    test_cpu_sweep();
    test_toggle();
    test_ini_abort();
    test_all_three();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
